pipeline_sequencer: RTL and testbench

- Controller for the 4-stage MAC datapath: MULTIPLY | ADDITION | SUM | ACCUMULATE.
- For one neuron it issues N operand chunks of 8 products each and drives the three inter-stage register enables plus the accumulator enable/clear. It tracks per-stage valid bits so bubbles never corrupt the sum.
- Returns one result per neuron over a valid/ready handshake.
- Sits between the operand buffer, the pipeline registers, and the result writeback.

---
 rtl/pipeline_seq_pkg.sv | 15 +
 rtl/pipe_valid_shift.sv | 32 +++
 rtl/pipeline_sequencer.sv | 136 +++++++++++++
 tb/tb_pipeline_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_seq_pkg.sv
// Shared types and constants for the MAC pipeline sequencer.
package pipeline_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      RESULT = 2'd3
   } seq_state_t;

   localparam int PIPE_STAGES = 3;
   localparam int CNT_W_DEF   = 16;
   localparam int PERF_W_DEF  = 32;

endpackage

// File: rtl/pipe_valid_shift.sv
// Per-stage valid tracking for the MULTIPLY..ACCUMULATE pipeline; each valid bit
// enables the register feeding the next stage so bubbles never reach the accumulator.
module pipe_valid_shift
   import pipeline_seq_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic shift_in,
   output logic stage_2_en,
   output logic stage_3_en,
   output logic acc_en,
   output logic drained
);

   logic [PIPE_STAGES-1:0] v_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
      end else begin
         v_q <= {v_q[PIPE_STAGES-2:0], shift_in};
      end
   end

   assign stage_2_en = v_q[0];
   assign stage_3_en = v_q[1];
   assign acc_en     = v_q[PIPE_STAGES-1];

   // True when the pipe will hold nothing after this edge: the last acc_en is firing now.
   assign drained = ~|{v_q[PIPE_STAGES-2:0], shift_in};

endmodule

// File: rtl/pipeline_sequencer.sv
// Sequencer for the 4-stage MAC datapath: issues operand chunks, drives stage and
// accumulator enables, returns one result per neuron. Perf counters under PIPE_SEQ_PERF_EN.
//
//   state  | meaning
//   IDLE   | waiting for start with a non-zero chunk count
//   RUN    | issuing chunks while the buffer has data
//   DRAIN  | all chunks issued, flushing the pipeline into the accumulator
//   RESULT | final sum held, waiting for the consumer handshake
module pipeline_sequencer
   import pipeline_seq_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int PERF_W = PERF_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_chunks,
   input  logic              in_valid,
   output logic              operand_rd,
   output logic              stage_1_en,
   output logic              stage_2_en,
   output logic              stage_3_en,
   output logic              acc_en,
   output logic              acc_clr,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              busy,
   output logic              done,
   output logic [PERF_W-1:0] perf_cycles,
   output logic [PERF_W-1:0] perf_bubbles
);

   seq_state_t        state_q, state_d;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  issue_cnt_q;
   logic              issue;
   logic              last_issue;
   logic              start_ok;
   logic              drained;

   assign start_ok   = (state_q == IDLE) && start && (num_chunks != '0);
   assign issue      = (state_q == RUN) && in_valid && (issue_cnt_q < count_q);
   assign last_issue = issue && (issue_cnt_q == (count_q - CNT_W'(1)));

   assign operand_rd = issue;
   assign stage_1_en = issue;
   assign busy       = (state_q != IDLE);

   pipe_valid_shift u_valid_shift (
      .clk        (clk),
      .rst        (rst),
      .shift_in   (issue),
      .stage_2_en (stage_2_en),
      .stage_3_en (stage_3_en),
      .acc_en     (acc_en),
      .drained    (drained)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_clr   = 1'b0;
      res_valid = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_ok) begin
               acc_clr = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (last_issue) state_d = DRAIN;
         end
         DRAIN: begin
            if (drained) state_d = RESULT;
         end
         RESULT: begin
            res_valid = 1'b1;
            if (res_ready) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= '0;
         issue_cnt_q <= '0;
      end else if (start_ok) begin
         count_q     <= num_chunks;
         issue_cnt_q <= '0;
      end else if (issue) begin
         issue_cnt_q <= issue_cnt_q + CNT_W'(1);
      end
   end

`ifdef PIPE_SEQ_PERF_EN
   logic [PERF_W-1:0] perf_cycles_q;
   logic [PERF_W-1:0] perf_bubbles_q;

   // Saturating; values survive RESULT/IDLE so software can read them after done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cycles_q  <= '0;
         perf_bubbles_q <= '0;
      end else if (acc_clr) begin
         perf_cycles_q  <= '0;
         perf_bubbles_q <= '0;
      end else begin
         if (((state_q == RUN) || (state_q == DRAIN)) && !(&perf_cycles_q))
            perf_cycles_q <= perf_cycles_q + PERF_W'(1);
         if ((state_q == RUN) && !issue && !(&perf_bubbles_q))
            perf_bubbles_q <= perf_bubbles_q + PERF_W'(1);
      end
   end

   assign perf_cycles  = perf_cycles_q;
   assign perf_bubbles = perf_bubbles_q;
`else
   assign perf_cycles  = '0;
   assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus randomized neurons
// checked cycle by cycle against an issue-list reference model.
module tb_pipeline_sequencer;

   localparam int CNT_W  = 16;
   localparam int PERF_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [CNT_W-1:0]  num_chunks;
   logic              in_valid;
   logic              operand_rd;
   logic              stage_1_en;
   logic              stage_2_en;
   logic              stage_3_en;
   logic              acc_en;
   logic              acc_clr;
   logic              res_valid;
   logic              res_ready;
   logic              busy;
   logic              done;
   logic [PERF_W-1:0] perf_cycles;
   logic [PERF_W-1:0] perf_bubbles;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipeline_sequencer #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .num_chunks   (num_chunks),
      .in_valid     (in_valid),
      .operand_rd   (operand_rd),
      .stage_1_en   (stage_1_en),
      .stage_2_en   (stage_2_en),
      .stage_3_en   (stage_3_en),
      .acc_en       (acc_en),
      .acc_clr      (acc_clr),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .busy         (busy),
      .done         (done),
      .perf_cycles  (perf_cycles),
      .perf_bubbles (perf_bubbles)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Perf expectations: RUN spans cycles 1..T, DRAIN T+1..T+3.
   task automatic check_perf(input string tag, input int n, input int t_last);
`ifdef PIPE_SEQ_PERF_EN
      check({tag, "_perf_cycles"}, perf_cycles, t_last + 3);
      check({tag, "_perf_bubbles"}, perf_bubbles, t_last - n);
`else
      check({tag, "_perf_cycles"}, perf_cycles, 0);
      check({tag, "_perf_bubbles"}, perf_bubbles, 0);
`endif
   endtask

   // One neuron from its start cycle (c=0) to its done cycle. Model: chunk k issues
   // on the k-th in_valid cycle from cycle 1, reaches the accumulator 3 cycles later,
   // and the result is valid from 4 cycles after the last issue until accepted.
   task automatic run_neuron(input int n, input int p_valid, input int ready_delay,
                             input bit stray_start, input bit use_pat,
                             input logic [31:0] pat, output int t_last);
      bit iss [0:1023];
      int issued   = 0;
      int wait_cnt = 0;
      int t        = -1;
      bit finished = 0;
      bit iv, rr, e_valid, e_rd, e_done;
      foreach (iss[k]) iss[k] = 1'b0;
      for (int c = 0; c < 600 && !finished; c++) begin
         @(negedge clk);
         e_valid = (t >= 0) && (c >= t + 4);
         if (c == 0) begin
            start      = 1'b1;
            num_chunks = CNT_W'(n);
         end else begin
            start      = stray_start && ($urandom_range(0, 3) == 0);
            num_chunks = CNT_W'(9);
         end
         if (use_pat)
            iv = (c >= 1 && c <= 32) ? pat[c-1] : 1'b1;
         else
            iv = ($urandom_range(0, 99) < p_valid);
         in_valid = iv;
         rr = e_valid ? (wait_cnt >= ready_delay) : 1'($urandom_range(0, 1));
         res_ready = rr;
         e_rd   = (c >= 1) && (issued < n) && iv;
         e_done = e_valid && rr;
         #1;
         check("acc_clr",    acc_clr,    c == 0);
         check("operand_rd", operand_rd, e_rd);
         check("stage_1_en", stage_1_en, e_rd);
         check("stage_2_en", stage_2_en, iss[c+2]);
         check("stage_3_en", stage_3_en, iss[c+1]);
         check("acc_en",     acc_en,     iss[c]);
         check("res_valid",  res_valid,  e_valid);
         check("done",       done,       e_done);
         check("busy",       busy,       c >= 1);
         if (e_rd) begin
            iss[c+3] = 1'b1;
            issued++;
            if (issued == n) t = c;
         end
         if (e_valid) wait_cnt++;
         if (e_done) finished = 1'b1;
      end
      check("neuron_completed", finished, 1'b1);
      t_last = t;
   endtask

   initial begin
      int t;
      rst        = 1'b1;
      start      = 1'b0;
      num_chunks = '0;
      in_valid   = 1'b0;
      res_ready  = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_busy",      busy,         0);
      check("rst_res_valid", res_valid,    0);
      check("rst_acc_en",    acc_en,       0);
      check("rst_acc_clr",   acc_clr,      0);
      check("rst_operand",   operand_rd,   0);
      check("rst_done",      done,         0);
      check("rst_perf_cyc",  perf_cycles,  0);
      check("rst_perf_bub",  perf_bubbles, 0);
      rst = 1'b0;

      // 4 chunks, buffer always ready, consumer always ready
      run_neuron(4, 100, 0, 1'b0, 1'b0, 32'h0, t);
      check("full_rate_t_last", t, 4);
      check_perf("full_rate", 4, t);

      // 3 chunks with in_valid 1,0,0,1,1
      run_neuron(3, 0, 0, 1'b0, 1'b1, 32'b11001, t);
      check("bubble_t_last", t, 5);
      check_perf("bubble", 3, t);

      // single chunk, consumer stalls 5 cycles
      run_neuron(1, 100, 5, 1'b0, 1'b0, 32'h0, t);
      check("stall_t_last", t, 1);

      // zero-chunk start is ignored
      @(negedge clk);
      start = 1'b1; num_chunks = '0; in_valid = 1'b1; res_ready = 1'b0;
      #1;
      check("zero_acc_clr", acc_clr, 0);
      check("zero_busy",    busy,    0);
      @(negedge clk);
      start = 1'b0;
      #1;
      check("zero_busy_after", busy, 0);

      // stray starts (num_chunks=9) while busy must not disturb a 6-chunk neuron
      run_neuron(6, 70, 2, 1'b1, 1'b0, 32'h0, t);

      // reset in DRAIN with the pipe partly full
      @(negedge clk);
      start = 1'b1; num_chunks = CNT_W'(2); in_valid = 1'b1; res_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("drain_stage_3_en", stage_3_en, 1);
      check("drain_busy",       busy,       1);
      rst = 1'b1;
      #1;
      check("rst_drain_busy",   busy,       0);
      check("rst_drain_s2",     stage_2_en, 0);
      check("rst_drain_s3",     stage_3_en, 0);
      check("rst_drain_acc",    acc_en,     0);
      check("rst_drain_valid",  res_valid,  0);
      @(negedge clk);
      rst = 1'b0;
      run_neuron(2, 100, 0, 1'b0, 1'b0, 32'h0, t);
      check("post_rst_t_last", t, 2);

      // back-to-back neurons
      run_neuron(2, 100, 0, 1'b0, 1'b0, 32'h0, t);
      run_neuron(5, 100, 0, 1'b0, 1'b0, 32'h0, t);
      check("b2b_t_last", t, 5);
      check_perf("b2b", 5, t);

      // randomized neurons
      for (int i = 0; i < 20; i++) begin
         int n;
         n = $urandom_range(1, 12);
         run_neuron(n, $urandom_range(30, 100), $urandom_range(0, 4), 1'b1, 1'b0, 32'h0, t);
         check_perf("rand", n, t);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
